// File: rtl/dot_vec_packer_if.sv
// Stream bundle around the dot-vector packer: element beats in, 4-lane vectors out.
// The master side feeds elements and plays the engine; the slave side is the packer.
interface dot_vec_packer_if #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int VEC_LEN = 4
);
    // element stream
    logic                      s_valid;
    logic                      s_ready;
    logic signed [A_WIDTH-1:0] s_a;
    logic signed [B_WIDTH-1:0] s_b;
    logic                      s_last;

    // vector issue port towards the dot-product engine
    logic signed [A_WIDTH-1:0] m_a [0:VEC_LEN-1];
    logic signed [B_WIDTH-1:0] m_b [0:VEC_LEN-1];
    logic                      m_valid;
    logic                      m_ready;

    // status
    logic                      frame_err;
    logic [15:0]               vec_count;

    modport master (
        output s_valid, s_a, s_b, s_last, m_ready,
        input  s_ready, m_a, m_b, m_valid, frame_err, vec_count
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, m_ready,
        output s_ready, m_a, m_b, m_valid, frame_err, vec_count
    );
endinterface

// File: rtl/dot_vec_packer.sv
// Serial-to-vector front end for the dot-product engine.
// Beats fill a 4-lane assembly buffer; a full buffer moves to the issue register,
// which is offered to the engine and then held for HOLD_CYCLES after acceptance.
module dot_vec_packer #(
    parameter int A_WIDTH     = 8,
    parameter int B_WIDTH     = 8,
    parameter int VEC_LEN     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dot_vec_packer_if.slave bus
);
    // Parameter sanity: the engine only consumes 4-element vectors.
    if (VEC_LEN != 4) begin : g_bad_vec_len
        $fatal(1, "dot_vec_packer: VEC_LEN must be 4");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "dot_vec_packer: HOLD_CYCLES must be >= 1");
    end

    localparam int                IDX_W    = 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam int                HOLD_W   = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    // issue FSM encoding
    localparam logic [1:0] I_IDLE  = 2'd0;
    localparam logic [1:0] I_OFFER = 2'd1;
    localparam logic [1:0] I_HOLD  = 2'd2;

    // assembly side
    logic [IDX_W-1:0]          idx;
    logic                      asm_full;
    logic signed [A_WIDTH-1:0] asm_a [0:VEC_LEN-1];
    logic signed [B_WIDTH-1:0] asm_b [0:VEC_LEN-1];
    logic                      frame_err_q;

    // issue side
    logic [1:0]                state;
    logic [HOLD_W-1:0]         hold_cnt;
    logic                      m_valid_q;
    logic [15:0]               vec_count_q;
    logic signed [A_WIDTH-1:0] m_a_q [0:VEC_LEN-1];
    logic signed [B_WIDTH-1:0] m_b_q [0:VEC_LEN-1];

    logic accept;
    logic vec_end;
    logic transfer;

    assign accept   = bus.s_valid && !asm_full;
    // A vector closes on s_last or when the last lane is written, whichever comes first.
    assign vec_end  = accept && (bus.s_last || (idx == LAST_IDX));
    // The buffer never accepts while full, so this never coincides with a beat write.
    assign transfer = (state == I_IDLE) && asm_full;

    // Assembly control: lane index, full flag and framing-error pulse.
    // NOTE: sequential state uses non-blocking assignments so every term reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            asm_full    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (transfer) begin
                asm_full <= 1'b0;
            end
            if (accept) begin
                if (vec_end) begin
                    idx         <= '0;
                    asm_full    <= 1'b1;
                    // early last or missing last: s_last disagrees with the lane position
                    frame_err_q <= (bus.s_last != (idx == LAST_IDX));
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Assembly data: write the beat's lane and zero-fill the tail on an early last.
    // NOTE: no reset here; every lane is rewritten (data or zero) before a vector is marked full.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                if (IDX_W'(i) == idx) begin
                    asm_a[i] <= bus.s_a;
                    asm_b[i] <= bus.s_b;
                end else if (bus.s_last && (IDX_W'(i) > idx)) begin
                    asm_a[i] <= '0;
                    asm_b[i] <= '0;
                end
            end
        end
    end

    // Issue FSM: move the buffer into the issue register, offer it, then hold the lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= I_IDLE;
            hold_cnt    <= '0;
            m_valid_q   <= 1'b0;
            vec_count_q <= '0;
            for (int i = 0; i < VEC_LEN; i++) begin
                m_a_q[i] <= '0;
                m_b_q[i] <= '0;
            end
        end else begin
            case (state)
                I_IDLE: begin
                    if (asm_full) begin
                        m_a_q     <= asm_a;
                        m_b_q     <= asm_b;
                        m_valid_q <= 1'b1;
                        state     <= I_OFFER;
                    end
                end
                I_OFFER: begin
                    if (m_valid_q && bus.m_ready) begin
                        m_valid_q   <= 1'b0;
                        vec_count_q <= vec_count_q + 16'd1;
                        hold_cnt    <= HOLD_W'(HOLD_CYCLES);
                        state       <= I_HOLD;
                    end
                end
                I_HOLD: begin
                    // lanes stay put while the engine loads them
                    if (hold_cnt == HOLD_W'(1)) begin
                        state <= I_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state     <= I_IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready   = !asm_full;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_a       = m_a_q;
    assign bus.m_b       = m_b_q;
    assign bus.frame_err = frame_err_q;
    assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_dot_vec_packer.sv
// Directed bench for dot_vec_packer: a vector table plus back-pressure and reset sequences.
module tb_dot_vec_packer;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int VL = 4;
    localparam int HC = 2;

    typedef logic [0:3][7:0] lanes_t;

    typedef struct {
        int     n_beats;
        int     last_at;   // beat index carrying s_last, -1 for none
        lanes_t a;
        lanes_t b;
        lanes_t exp_a;
        lanes_t exp_b;
        bit     exp_err;
        int     exp_dot;
    } vec_rec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dot_vec_packer_if #(.A_WIDTH(AW), .B_WIDTH(BW), .VEC_LEN(VL)) bus ();

    dot_vec_packer #(
        .A_WIDTH(AW), .B_WIDTH(BW), .VEC_LEN(VL), .HOLD_CYCLES(HC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    vec_rec_t tbl [6];
    int       n_vec     = 0;
    int       n_err     = 0;
    int       fe_cycles = 0;
    int       exp_vc    = 0;
    int       last_dot  = 0;
    lanes_t   cap_a [$];
    lanes_t   cap_b [$];
    lanes_t   prev_a, prev_b;
    bit       prev_valid = 1'b0;

    function automatic lanes_t pk(int x0, int x1, int x2, int x3);
        lanes_t r;
        r[0] = 8'(x0);
        r[1] = 8'(x1);
        r[2] = 8'(x2);
        r[3] = 8'(x3);
        return r;
    endfunction

    function automatic lanes_t cur_a();
        lanes_t r;
        for (int i = 0; i < 4; i++) r[i] = bus.m_a[i];
        return r;
    endfunction

    function automatic lanes_t cur_b();
        lanes_t r;
        for (int i = 0; i < 4; i++) r[i] = bus.m_b[i];
        return r;
    endfunction

    // engine stand-in: signed dot product of the presented lanes
    function automatic int dot_now();
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(bus.m_a[i]) * int'(bus.m_b[i]);
        return s;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_pair(input string name, input lanes_t got, input lanes_t exp);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s[%0d]", name, i), $signed(got[i]), $signed(exp[i]));
    endtask

    task automatic check_lanes(input string name, input lanes_t ea, input lanes_t eb);
        check_pair({name, "_a"}, cur_a(), ea);
        check_pair({name, "_b"}, cur_b(), eb);
    endtask

    // Engine-side monitor: frame_err cycles, handshake capture, lane stability while valid.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cycles++;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            cap_a.push_back(cur_a());
            cap_b.push_back(cur_b());
            last_dot = dot_now();
        end
        if (prev_valid && bus.m_valid === 1'b1) begin
            check_pair("stable_a", cur_a(), prev_a);
            check_pair("stable_b", cur_b(), prev_b);
        end
        prev_valid = (bus.m_valid === 1'b1);
        prev_a     = cur_a();
        prev_b     = cur_b();
    end

    // One beat: present it, wait (bounded) for s_ready, leave #1 after the accepting edge.
    task automatic send_beat(input int a, input int b, input bit last);
        int w = 0;
        bus.s_valid = 1'b1;
        bus.s_a     = 8'(a);
        bus.s_b     = 8'(b);
        bus.s_last  = last;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (w >= 60) check("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_vec(input lanes_t a, input lanes_t b, input int last_at);
        for (int k = 0; k < 4; k++)
            send_beat($signed(a[k]), $signed(b[k]), k == last_at);
    endtask

    task automatic wait_caps(input int n);
        int w = 0;
        while (cap_a.size() < n && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("capture_count", cap_a.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t v1a, v1b, v2a, v2b, v3a, v3b, zero;
        int     fe0;

        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        reset       = 1'b1;
        zero        = pk(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_vec_count", bus.vec_count, 0);
        check_lanes("rst", zero, zero);
        @(posedge clk);
        #1;

        // {n_beats, last_at, a, b, exp_a, exp_b, exp_err, exp_dot}
        tbl[0] = '{4,  3, pk(1, 2, 3, 4), pk(5, 6, 7, 8),
                   pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 70};
        tbl[1] = '{4,  3, pk(-128, -128, 127, 127), pk(127, -128, 127, -128),
                   pk(-128, -128, 127, 127), pk(127, -128, 127, -128), 1'b0, 1};
        tbl[2] = '{2,  1, pk(9, 10, 0, 0), pk(-1, -2, 0, 0),
                   pk(9, 10, 0, 0), pk(-1, -2, 0, 0), 1'b1, -29};
        tbl[3] = '{4, -1, pk(11, 12, 13, 14), pk(21, 22, 23, 24),
                   pk(11, 12, 13, 14), pk(21, 22, 23, 24), 1'b1, 1130};
        tbl[4] = '{4,  3, pk(15, 16, 17, 18), pk(25, 26, 27, 28),
                   pk(15, 16, 17, 18), pk(25, 26, 27, 28), 1'b0, 1754};
        tbl[5] = '{1,  0, pk(-1, 0, 0, 0), pk(100, 0, 0, 0),
                   pk(-1, 0, 0, 0), pk(100, 0, 0, 0), 1'b1, -100};

        for (int t = 0; t < 6; t++) begin
            fe0 = fe_cycles;
            for (int k = 0; k < tbl[t].n_beats; k++)
                send_beat($signed(tbl[t].a[k]), $signed(tbl[t].b[k]), k == tbl[t].last_at);
            // last beat accepted in cycle c; now in c+1
            @(negedge clk);
            check($sformatf("t%0d_valid_c1", t), bus.m_valid, 0);
            check($sformatf("t%0d_ferr_c1", t), bus.frame_err, tbl[t].exp_err);
            @(negedge clk);
            check($sformatf("t%0d_valid_c2", t), bus.m_valid, 1);
            check_lanes($sformatf("t%0d_offer", t), tbl[t].exp_a, tbl[t].exp_b);
            @(negedge clk);
            check($sformatf("t%0d_valid_h1", t), bus.m_valid, 0);
            check_lanes($sformatf("t%0d_hold1", t), tbl[t].exp_a, tbl[t].exp_b);
            @(negedge clk);
            check_lanes($sformatf("t%0d_hold2", t), tbl[t].exp_a, tbl[t].exp_b);
            repeat (3) @(negedge clk);
            check($sformatf("t%0d_ferr_cycles", t), fe_cycles - fe0, tbl[t].exp_err);
            check($sformatf("t%0d_dot", t), last_dot, tbl[t].exp_dot);
            exp_vc++;
            check($sformatf("t%0d_vec_count", t), bus.vec_count, exp_vc);
            @(posedge clk);
            #1;
        end

        // back-pressure: three vectors while the engine stalls for 20 cycles
        v1a = pk(-5, 6, -7, 8);     v1b = pk(1, 2, 3, 4);
        v2a = pk(20, 21, 22, 23);   v2b = pk(-20, -21, -22, -23);
        v3a = pk(127, -128, 0, 1);  v3b = pk(0, 1, 2, 3);
        cap_a.delete();
        cap_b.delete();
        bus.m_ready = 1'b0;
        fork
            begin
                send_vec(v1a, v1b, 3);
                send_vec(v2a, v2b, 3);
                send_vec(v3a, v3b, 3);
            end
            begin
                repeat (20) @(negedge clk);
                check("bp_s_ready_low", bus.s_ready, 0);
                check("bp_m_valid", bus.m_valid, 1);
                check_lanes("bp_first_held", v1a, v1b);
                check("bp_vec_count_stalled", bus.vec_count, exp_vc);
                @(posedge clk);
                #1 bus.m_ready = 1'b1;
            end
        join
        wait_caps(3);
        if (cap_a.size() >= 3) begin
            check_pair("bp_v1_a", cap_a[0], v1a);
            check_pair("bp_v1_b", cap_b[0], v1b);
            check_pair("bp_v2_a", cap_a[1], v2a);
            check_pair("bp_v2_b", cap_b[1], v2b);
            check_pair("bp_v3_a", cap_a[2], v3a);
            check_pair("bp_v3_b", cap_b[2], v3b);
        end
        repeat (2) @(negedge clk);
        exp_vc += 3;
        check("bp_vec_count", bus.vec_count, exp_vc);

        // reset while one vector is offered and another is half assembled
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        send_vec(pk(40, 41, 42, 43), pk(1, 1, 1, 1), 3);
        send_beat(50, 51, 1'b0);
        send_beat(52, 53, 1'b0);
        @(negedge clk);
        check("mid_m_valid", bus.m_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_m_valid", bus.m_valid, 0);
        check("mrst_vec_count", bus.vec_count, 0);
        check("mrst_s_ready", bus.s_ready, 1);
        check_lanes("mrst", zero, zero);
        exp_vc = 0;
        @(posedge clk);
        #1;
        cap_a.delete();
        cap_b.delete();
        fe0 = fe_cycles;
        bus.m_ready = 1'b1;
        send_vec(pk(-31, 32, -33, 34), pk(7, -8, 9, -10), 3);
        wait_caps(1);
        if (cap_a.size() >= 1) begin
            check_pair("post_rst_a", cap_a[0], pk(-31, 32, -33, 34));
            check_pair("post_rst_b", cap_b[0], pk(7, -8, 9, -10));
        end
        repeat (3) @(negedge clk);
        check("post_rst_ferr", fe_cycles - fe0, 0);
        check("post_rst_vec_count", bus.vec_count, exp_vc + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
